evu_event_counter: RTL and testbench
====================================

Name: evu_event_counter

Overview:
- Downstream consumer of the event unit's SPU output bundle (e_id / e_info).
- Counts each selected event line in a per-line saturating counter, filtered by privilege level.
- Raises a threshold interrupt when an enabled counter reaches its limit.
- On a PC-match event, captures a snapshot record of the addressed counter into a small FIFO, drained through a valid/ready handshake.

Parameters:
- NUM_EVENTS, 4, number of mux event lines (e_id bits [NUM_EVENTS-1:0]); e_id bit NUM_EVENTS is the PC-match flag.
- CNT_WIDTH, 32, width of each event counter.
- ASID_WIDTH, 16, ASID width carried in e_info.
- SNAP_DEPTH, 4, snapshot FIFO depth; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- e_id_i  in  NUM_EVENTS+1  event pulses; MSB is PC match.
- e_info_i  in  ASID_WIDTH+4  {counter_no[1:0], priv[1:0], asid}; priv encoding: 01=M, 10=S, 11=U, 00=unknown.
- en_mask_i  in  NUM_EVENTS  per-counter count enable.
- priv_filter_i  in  3  {U,S,M} privilege levels that are counted.
- clear_i  in  NUM_EVENTS  per-counter synchronous clear pulse.
- threshold_i  in  CNT_WIDTH  interrupt threshold; 0 disables the interrupt.
- cnt_o  out  NUM_EVENTS*CNT_WIDTH  counter values; counter i at slice [i*CNT_WIDTH +: CNT_WIDTH].
- ovf_o  out  NUM_EVENTS  sticky saturation flags.
- irq_o  out  1  threshold interrupt.
- snap_valid_o  out  1  snapshot FIFO not empty.
- snap_ready_i  in  1  consumer accepts the head entry.
- snap_data_o  out  CNT_WIDTH+ASID_WIDTH+4  {counter_no, priv, asid, count}.
- drop_cnt_o  out  8  saturating count of snapshots dropped because the FIFO was full.

Behaviour:
- Reset (async, rst_i=1): all counters 0, ovf_o=0, irq_o=0, FIFO empty (snap_valid_o=0, snap_data_o=0), drop_cnt_o=0.
- Qualified priv: priv=01 needs priv_filter_i[0]; 10 needs [1]; 11 needs [2]; 00 is never counted.
- Increment: counter i increments by 1 on the next edge when e_id_i[i] & en_mask_i[i] & qualified priv.
- Saturation: at all-ones the counter holds; ovf_o[i] sets and stays set.
- Clear: clear_i[i] zeroes counter i and ovf_o[i]. Clear wins over a same-cycle increment.
- irq_o: registered. irq_o=1 in the cycle after any i satisfies en_mask_i[i] & (cnt[i] >= threshold_i) & (threshold_i != 0). Level, not sticky; drops one cycle after the condition clears.
- Snapshot push: when e_id_i[NUM_EVENTS]=1, push {counter_no, priv, asid, cnt_q[counter_no]}.
  - count is the pre-increment registered value.
  - Snapshots are not subject to the priv filter.
  - If counter_no >= NUM_EVENTS, the count field is 0.
- FIFO: first-word fall-through; head is visible on snap_data_o while snap_valid_o=1. Pop on snap_valid_o & snap_ready_i.
- Full FIFO: push is accepted only if a pop occurs in the same cycle; otherwise the record is dropped and drop_cnt_o increments, saturating at 255.
- Empty FIFO: snap_valid_o=0 and snap_data_o holds its last value; snap_ready_i is ignored.
- Simultaneous push and pop on an empty FIFO: the push is stored and snap_valid_o rises the next cycle (no bypass).
- Latency: event pulse to cnt_o is 1 cycle; PC match to snap_valid_o is 1 cycle.
- Mid-operation reset: aborts everything immediately; FIFO contents are lost.

Optional Feature:
- Macro: EVU_CNT_SNAP_CLEAR_EN.
- Defined: an accepted snapshot push also clears the snapped counter and its ovf flag (read-and-clear). An increment in the same cycle is lost; clear priority applies.
- Undefined: snapshots are non-destructive.

Decomposition:
- evu_pkg holds:
  - priv encoding constants (EVU_PRIV_M=2'b01, EVU_PRIV_S=2'b10, EVU_PRIV_U=2'b11);
  - evu_snap_t packed struct {counter_no, priv, asid, count};
  - the e_info field offsets.
- Sub-module evu_snap_fifo: parameterised FWFT FIFO with push/pop/full/empty; the counter bank lives in the top.

Test Plan:
- en_mask=4'hF, priv_filter=3'b111, pulse e_id[0] 10 times with priv=01 -> cnt[0]=10, other counters 0, ovf_o=0.
- Same stimulus as above with priv_filter=3'b001 and priv=11 -> cnt[0] stays 0.
- Preload cnt[2]=32'hFFFF_FFFE, pulse e_id[2] 3 times -> cnt[2]=32'hFFFF_FFFF, ovf_o[2]=1. Then clear_i[2] together with an e_id[2] pulse -> cnt[2]=0, ovf_o[2]=0.
- threshold=5, en_mask[1]=1, 5 pulses on e_id[1] -> irq_o=1 one cycle after cnt[1]=5. Then threshold=0 -> irq_o=0 the next cycle.
- snap_ready_i=0, 6 PC-match pulses with counter_no=1 -> 4 entries stored, drop_cnt_o=2. Raise ready -> 4 beats with count equal to pre-increment cnt[1]; then snap_valid_o=0.
- With EVU_CNT_SNAP_CLEAR_EN, cnt[3]=7 and a PC match with counter_no=3 -> snapshot count=7, cnt[3]=0 the next cycle. Without the macro -> cnt[3] stays 7.

Source files
------------

// File: rtl/evu_pkg.sv
// evu_pkg: shared privilege encodings, e_info field offsets and the snapshot record layout
package evu_pkg;
    localparam logic [1:0] EVU_PRIV_M = 2'b01;
    localparam logic [1:0] EVU_PRIV_S = 2'b10;
    localparam logic [1:0] EVU_PRIV_U = 2'b11;
    localparam int EVU_CNT_W  = 32;
    localparam int EVU_ASID_W = 16;
    // e_info = {counter_no, priv, asid}; priv/counter_no offsets are relative to the top of asid
    localparam int EVU_INFO_ASID_LSB = 0;
    localparam int EVU_INFO_PRIV_OFS = 0;
    localparam int EVU_INFO_CNO_OFS  = 2;
    typedef struct packed {
        logic [1:0]            counter_no;
        logic [1:0]            priv;
        logic [EVU_ASID_W-1:0] asid;
        logic [EVU_CNT_W-1:0]  count;
    } evu_snap_t;
endpackage

// File: rtl/evu_snap_fifo.sv
// evu_snap_fifo: first-word fall-through FIFO; data_o holds the last popped word while empty
module evu_snap_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [W-1:0]  last_q, last_d;
    logic          push_ok, pop_ok;
    always_comb begin
        empty_o = cnt_q == '0;
        full_o  = cnt_q == (AW+1)'(DEPTH);
        pop_ok  = pop_i & ~empty_o;
        push_ok = push_i & (~full_o | pop_ok);
        wr_d    = wr_q + AW'(push_ok);
        rd_d    = rd_q + AW'(pop_ok);
        cnt_d   = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        last_d  = pop_ok ? mem_q[rd_q] : last_q;
        data_o  = empty_o ? last_q : mem_q[rd_q];
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/evu_event_counter.sv
// evu_event_counter: privilege-filtered saturating event counters, threshold irq and PC-match snapshot FIFO.
// Define EVU_CNT_SNAP_CLEAR_EN to make accepted snapshots read-and-clear the snapped counter.
module evu_event_counter
    import evu_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int ASID_WIDTH = 16,
    parameter int SNAP_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_EVENTS:0]              e_id_i,
    input  logic [ASID_WIDTH+3:0]            e_info_i,
    input  logic [NUM_EVENTS-1:0]            en_mask_i,
    input  logic [2:0]                       priv_filter_i,
    input  logic [NUM_EVENTS-1:0]            clear_i,
    input  logic [CNT_WIDTH-1:0]             threshold_i,
    output logic [NUM_EVENTS*CNT_WIDTH-1:0]  cnt_o,
    output logic [NUM_EVENTS-1:0]            ovf_o,
    output logic                             irq_o,
    output logic                             snap_valid_o,
    input  logic                             snap_ready_i,
    output logic [CNT_WIDTH+ASID_WIDTH+3:0]  snap_data_o,
    output logic [7:0]                       drop_cnt_o
);
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_EVENTS];
    logic [NUM_EVENTS-1:0] ovf_q, ovf_d, inc, sat, clr, snap_clr;
    logic                  irq_q, irq_d;
    logic [7:0]            drop_q, drop_d;
    logic [1:0]            priv, cno;
    logic [ASID_WIDTH-1:0] asid;
    logic [CNT_WIDTH-1:0]  snap_cnt;
    logic                  priv_ok, push, pop, acc, full, empty;
    assign asid = e_info_i[EVU_INFO_ASID_LSB +: ASID_WIDTH];
    assign priv = e_info_i[ASID_WIDTH+EVU_INFO_PRIV_OFS +: 2];
    assign cno  = e_info_i[ASID_WIDTH+EVU_INFO_CNO_OFS +: 2];
`ifdef EVU_CNT_SNAP_CLEAR_EN
    always_comb begin
        for (int i = 0; i < NUM_EVENTS; i++) snap_clr[i] = acc & (32'(cno) == i);
    end
`else
    assign snap_clr = '0;
`endif
    always_comb begin
        priv_ok = (priv == EVU_PRIV_M & priv_filter_i[0]) |
                  (priv == EVU_PRIV_S & priv_filter_i[1]) |
                  (priv == EVU_PRIV_U & priv_filter_i[2]);
        // counter_no beyond the bank matches no entry and snapshots a zero count
        snap_cnt = '0;
        for (int i = 0; i < NUM_EVENTS; i++) if (32'(cno) == i) snap_cnt = cnt_q[i];
        push   = e_id_i[NUM_EVENTS];
        pop    = ~empty & snap_ready_i;
        acc    = push & (~full | pop);
        drop_d = (push & ~acc & drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
        irq_d  = 1'b0;
        cnt_o  = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            inc[i]   = e_id_i[i] & en_mask_i[i] & priv_ok;
            sat[i]   = &cnt_q[i];
            clr[i]   = clear_i[i] | snap_clr[i];
            cnt_d[i] = clr[i] ? '0 : (inc[i] & ~sat[i]) ? cnt_q[i] + CNT_WIDTH'(1) : cnt_q[i];
            ovf_d[i] = ~clr[i] & (ovf_q[i] | (inc[i] & sat[i]));
            irq_d    = irq_d | (en_mask_i[i] & (cnt_q[i] >= threshold_i));
            cnt_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
        irq_d = irq_d & (threshold_i != '0);
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= '0;
            ovf_q  <= '0;
            irq_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            for (int i = 0; i < NUM_EVENTS; i++) cnt_q[i] <= cnt_d[i];
            ovf_q  <= ovf_d;
            irq_q  <= irq_d;
            drop_q <= drop_d;
        end
    end
    evu_snap_fifo #(
        .W     (CNT_WIDTH+ASID_WIDTH+4),
        .DEPTH (SNAP_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({cno, priv, asid, snap_cnt}),
        .data_o  (snap_data_o),
        .full_o  (full),
        .empty_o (empty)
    );
    assign ovf_o        = ovf_q;
    assign irq_o        = irq_q;
    assign drop_cnt_o   = drop_q;
    assign snap_valid_o = ~empty;
endmodule

// File: tb/tb_evu_event_counter.sv
// tb_evu_event_counter: directed scenarios plus randomized traffic checked against a behavioural model.
// 8-bit counters make saturation reachable in a short run.
module tb_evu_event_counter;
    localparam int NE = 4, CW = 8, AW = 16, SD = 4, DW = CW + AW + 4;
    logic              clk = 1'b0, rst;
    logic [NE:0]       e_id;
    logic [AW+3:0]     e_info;
    logic [NE-1:0]     en_mask, clear, ovf;
    logic [2:0]        pf;
    logic [CW-1:0]     thr;
    logic [NE*CW-1:0]  cnt;
    logic              irq, sv, sr;
    logic [DW-1:0]     sd;
    logic [7:0]        drop;
    logic [CW-1:0]     m_cnt [NE];
    logic [NE-1:0]     m_ovf;
    logic              m_irq;
    logic [DW-1:0]     m_q [$];
    logic [DW-1:0]     m_last;
    int                m_drop;
    int                n_chk = 0, n_fail = 0;

    evu_event_counter #(.NUM_EVENTS(NE), .CNT_WIDTH(CW), .ASID_WIDTH(AW), .SNAP_DEPTH(SD)) dut (
        .clk_i(clk), .rst_i(rst), .e_id_i(e_id), .e_info_i(e_info), .en_mask_i(en_mask),
        .priv_filter_i(pf), .clear_i(clear), .threshold_i(thr), .cnt_o(cnt), .ovf_o(ovf),
        .irq_o(irq), .snap_valid_o(sv), .snap_ready_i(sr), .snap_data_o(sd), .drop_cnt_o(drop));

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < NE; i++) m_cnt[i] = '0;
        m_ovf = '0; m_irq = 1'b0; m_q.delete(); m_last = '0; m_drop = 0;
    endtask

    task automatic tick();
        logic [1:0] priv, cno;
        logic ok, ni, pop, acc, c;
        logic [CW-1:0] nc [NE];
        logic [NE-1:0] no;
        logic [CW-1:0] snapc;
        priv = e_info[AW +: 2];
        cno  = e_info[AW+2 +: 2];
        ok = (priv == 2'd1 && pf[0]) || (priv == 2'd2 && pf[1]) || (priv == 2'd3 && pf[2]);
        ni = 1'b0;
        for (int i = 0; i < NE; i++) if (en_mask[i] && thr != 0 && m_cnt[i] >= thr) ni = 1'b1;
        snapc = (int'(cno) < NE) ? m_cnt[cno] : '0;
        pop = m_q.size() > 0 && sr;
        acc = e_id[NE] && (m_q.size() < SD || pop);
        for (int i = 0; i < NE; i++) begin
            nc[i] = m_cnt[i]; no[i] = m_ovf[i]; c = clear[i];
`ifdef EVU_CNT_SNAP_CLEAR_EN
            if (acc && int'(cno) == i) c = 1'b1;
`endif
            if (c) begin nc[i] = '0; no[i] = 1'b0; end
            else if (e_id[i] && en_mask[i] && ok) begin
                if (m_cnt[i] == '1) no[i] = 1'b1; else nc[i] = m_cnt[i] + 1'b1;
            end
        end
        @(posedge clk);
        for (int i = 0; i < NE; i++) m_cnt[i] = nc[i];
        m_ovf = no; m_irq = ni;
        if (pop) m_last = m_q.pop_front();
        if (acc) m_q.push_back({cno, priv, e_info[AW-1:0], snapc});
        else if (e_id[NE] && m_drop < 255) m_drop++;
        #1;
    endtask

    task automatic pulse(input int line, input int n);
        e_id = '0; e_id[line] = 1'b1;
        repeat (n) tick();
        e_id = '0;
    endtask

    task automatic clear_all();
        clear = '1; tick(); clear = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; e_id = '0; e_info = '0; en_mask = '0; clear = '0; pf = '0; thr = '0; sr = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (cnt !== '0 || ovf !== '0 || irq !== 1'b0) begin n_fail++; $display("FAIL reset_cnt cnt=%h ovf=%b irq=%b want all 0", cnt, ovf, irq); end
        n_chk++; if (sv !== 1'b0 || sd !== '0 || drop !== 8'd0) begin n_fail++; $display("FAIL reset_fifo valid=%b data=%h drop=%0d want 0", sv, sd, drop); end
        @(negedge clk); rst = 1'b0; #1;
    endtask

    task automatic test_count();
        en_mask = 4'hF; pf = 3'b111; e_info = {2'd0, 2'b01, 16'h1234};
        pulse(0, 10);
        n_chk++; if (cnt !== {8'd0, 8'd0, 8'd0, 8'd10}) begin n_fail++; $display("FAIL count10 got %h want 0000000a", cnt); end
        n_chk++; if (ovf !== 4'b0) begin n_fail++; $display("FAIL count10_ovf got %b want 0000", ovf); end
    endtask

    task automatic test_priv_filter();
        clear_all();
        pf = 3'b001; e_info = {2'd0, 2'b11, 16'h1234};
        pulse(0, 10);
        n_chk++; if (cnt[0 +: CW] !== 8'd0) begin n_fail++; $display("FAIL priv_u_filtered got %0d want 0", cnt[0 +: CW]); end
        e_info = {2'd0, 2'b00, 16'h1234}; pf = 3'b111;
        pulse(0, 2);
        n_chk++; if (cnt[0 +: CW] !== 8'd0) begin n_fail++; $display("FAIL priv_unknown got %0d want 0", cnt[0 +: CW]); end
        e_info = {2'd0, 2'b10, 16'h1234}; pf = 3'b010;
        pulse(0, 3);
        n_chk++; if (cnt[0 +: CW] !== 8'd3) begin n_fail++; $display("FAIL priv_s_counted got %0d want 3", cnt[0 +: CW]); end
    endtask

    task automatic test_saturation();
        clear_all();
        pf = 3'b111; e_info = {2'd0, 2'b01, 16'h0};
        pulse(2, 254);
        n_chk++; if (cnt[2*CW +: CW] !== 8'hFE || ovf[2] !== 1'b0) begin n_fail++; $display("FAIL sat_preload got %h ovf=%b want fe ovf=0", cnt[2*CW +: CW], ovf[2]); end
        pulse(2, 3);
        n_chk++; if (cnt[2*CW +: CW] !== 8'hFF || ovf[2] !== 1'b1) begin n_fail++; $display("FAIL sat_hold got %h ovf=%b want ff ovf=1", cnt[2*CW +: CW], ovf[2]); end
        clear = 4'b0100; e_id = 5'b00100; tick(); clear = '0; e_id = '0;
        n_chk++; if (cnt[2*CW +: CW] !== 8'h00 || ovf[2] !== 1'b0) begin n_fail++; $display("FAIL clear_wins got %h ovf=%b want 00 ovf=0", cnt[2*CW +: CW], ovf[2]); end
    endtask

    task automatic test_irq();
        clear_all();
        thr = 8'd5; en_mask = 4'b0010; e_info = {2'd0, 2'b01, 16'h0};
        pulse(1, 5);
        n_chk++; if (cnt[CW +: CW] !== 8'd5 || irq !== 1'b0) begin n_fail++; $display("FAIL irq_not_yet cnt=%0d irq=%b want 5 irq=0", cnt[CW +: CW], irq); end
        tick();
        n_chk++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_raise got %b want 1", irq); end
        thr = 8'd0; tick();
        n_chk++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disable got %b want 0", irq); end
    endtask

    task automatic test_snap();
        logic [DW-1:0] rec;
        rec = {2'd1, 2'b01, 16'hABCD, 8'd5};
        sr = 1'b0; e_info = {2'd1, 2'b01, 16'hABCD};
        pulse(NE, 6);
        n_chk++; if (sv !== 1'b1 || drop !== 8'd2) begin n_fail++; $display("FAIL snap_full valid=%b drop=%0d want 1 2", sv, drop); end
        sr = 1'b1;
        for (int b = 0; b < 4; b++) begin
            n_chk++; if (sv !== 1'b1 || sd !== rec) begin n_fail++; $display("FAIL snap_beat%0d valid=%b data=%h want 1 %h", b, sv, sd, rec); end
            tick();
        end
        n_chk++; if (sv !== 1'b0 || sd !== rec) begin n_fail++; $display("FAIL snap_empty valid=%b data=%h want 0 %h", sv, sd, rec); end
        sr = 1'b0;
    endtask

    task automatic test_snap_clear();
        clear_all();
        en_mask = 4'hF; pf = 3'b111; e_info = {2'd3, 2'b01, 16'h0042};
        pulse(3, 7);
        sr = 1'b1;
        pulse(NE, 1);
        n_chk++; if (sv !== 1'b1 || sd[CW-1:0] !== 8'd7 || sd[DW-1 -: 2] !== 2'd3) begin n_fail++; $display("FAIL snapclr_rec valid=%b data=%h want count 7 cno 3", sv, sd); end
`ifdef EVU_CNT_SNAP_CLEAR_EN
        n_chk++; if (cnt[3*CW +: CW] !== 8'd0) begin n_fail++; $display("FAIL snapclr_cnt got %0d want 0", cnt[3*CW +: CW]); end
`else
        n_chk++; if (cnt[3*CW +: CW] !== 8'd7) begin n_fail++; $display("FAIL snap_nondestr got %0d want 7", cnt[3*CW +: CW]); end
`endif
        tick(); sr = 1'b0;
    endtask

    task automatic test_random();
        logic [NE*CW-1:0] ec;
        logic [DW-1:0] ed;
        int bad;
        for (int n = 0; n < 3000; n++) begin
            e_id    = 5'($urandom);
            e_info  = 20'($urandom);
            en_mask = ($urandom % 8 == 0) ? 4'($urandom) : 4'hF;
            pf      = 3'($urandom);
            clear   = ($urandom % 24 == 0) ? 4'($urandom) : 4'h0;
            thr     = 8'($urandom % 40);
            sr      = ($urandom % 3 == 0);
            tick();
            for (int i = 0; i < NE; i++) ec[i*CW +: CW] = m_cnt[i];
            ed = (m_q.size() > 0) ? m_q[0] : m_last;
            bad = 0;
            n_chk++; if (cnt !== ec) begin n_fail++; bad++; $display("FAIL rnd_cnt @%0d got %h want %h", n, cnt, ec); end
            n_chk++; if (ovf !== m_ovf || irq !== m_irq) begin n_fail++; bad++; $display("FAIL rnd_ovf_irq @%0d got %b/%b want %b/%b", n, ovf, irq, m_ovf, m_irq); end
            n_chk++; if (sv !== (m_q.size() > 0) || sd !== ed) begin n_fail++; bad++; $display("FAIL rnd_snap @%0d got %b %h want %b %h", n, sv, sd, m_q.size() > 0, ed); end
            n_chk++; if (drop !== 8'(m_drop)) begin n_fail++; bad++; $display("FAIL rnd_drop @%0d got %0d want %0d", n, drop, m_drop); end
            if (bad != 0) break;
        end
        e_id = '0; clear = '0; sr = 1'b0;
    endtask

    task automatic test_mid_reset();
        en_mask = 4'hF; pf = 3'b111; e_info = {2'd0, 2'b01, 16'h0};
        pulse(0, 3);
        pulse(NE, 2);
        #2 rst = 1'b1;
        #1;
        n_chk++; if (cnt !== '0 || ovf !== '0 || irq !== 1'b0 || sv !== 1'b0 || sd !== '0 || drop !== 8'd0) begin
            n_fail++; $display("FAIL async_reset cnt=%h ovf=%b irq=%b valid=%b data=%h drop=%0d want 0", cnt, ovf, irq, sv, sd, drop);
        end
        model_reset();
        @(negedge clk); rst = 1'b0; #1;
    endtask

    initial begin
        test_reset();
        test_count();
        test_priv_filter();
        test_saturation();
        test_irq();
        test_snap();
        test_snap_clear();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
